// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One radix-2 iteration per cycle; the pipeline is stalled while an operation runs.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [CW-1:0]      r_count;
   logic               r_isDiv;
   logic               r_divByZero;
   logic               r_prodNeg;
   logic               r_quotNeg;
   logic               r_remNeg;
   logic [WIDTH-1:0]   r_operand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_isDiv;
   logic               w_isSigned;
   logic               w_negA;
   logic               w_negB;
   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic               w_divByZero;
   logic               w_accept;

   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulStep;
   logic [WIDTH:0]     w_divShift;
   logic [WIDTH:0]     w_divDiff;
   logic               w_divFits;
   logic [2*WIDTH-1:0] w_divStep;

   logic [2*WIDTH-1:0] w_product;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_resHi;
   logic [WIDTH-1:0]   w_resLo;

   // Request decode: op_i[1] selects divide, op_i[0] selects the unsigned variant.
   assign w_isDiv     = op_i[1];
   assign w_isSigned  = ~op_i[0];
   assign w_negA      = w_isSigned & src_a_i[WIDTH-1];
   assign w_negB      = w_isSigned & src_b_i[WIDTH-1];
   assign w_absA      = w_negA ? -src_a_i : src_a_i;
   assign w_absB      = w_negB ? -src_b_i : src_b_i;
   assign w_divByZero = w_isDiv & (src_b_i == '0);
   assign w_accept    = (r_state == IDLE) & start_i & ~flush_i;

   // Shift-add multiply: upper half accumulates, multiplier bits shift out of the bottom.
   assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
   assign w_mulStep = {w_mulSum, r_acc[WIDTH-1:1]};

   // Restoring divide: upper half is the remainder, lower half shifts dividend out and quotient in.
   assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_divDiff  = w_divShift - {1'b0, r_operand};
   assign w_divFits  = ~w_divDiff[WIDTH];
   assign w_divStep  = {(w_divFits ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_divFits};

   assign w_product = r_prodNeg ? -r_acc : r_acc;
   assign w_quot    = r_acc[WIDTH-1:0];
   assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
   assign w_resHi   = r_isDiv ? (r_remNeg ? -w_rem : w_rem) : w_product[2*WIDTH-1:WIDTH];
   assign w_resLo   = r_isDiv ? (r_quotNeg ? -w_quot : w_quot) : w_product[WIDTH-1:0];

   always_comb begin
      w_nextState = r_state;
      stall_o     = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy_o = 1'b0;
            if (w_accept) begin
               stall_o     = 1'b1;
               w_nextState = w_divByZero ? FIN : RUN;
            end
         end
         RUN: begin
            stall_o = 1'b1;
            if (flush_i) begin
               w_nextState = IDLE;
            end else if (r_count == LAST_ITER) begin
               w_nextState = FIN;
            end
         end
         FIN: begin
            done_o      = ~flush_i;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_isDiv     <= 1'b0;
         r_divByZero <= 1'b0;
         r_prodNeg   <= 1'b0;
         r_quotNeg   <= 1'b0;
         r_remNeg    <= 1'b0;
         r_operand   <= '0;
         r_acc       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
      end else begin
         r_state <= w_nextState;
         unique case (r_state)
            IDLE: begin
               if (hi_we_i) begin
                  r_hi <= wdata_i;
               end
               if (lo_we_i) begin
                  r_lo <= wdata_i;
               end
               // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
               if (w_accept) begin
                  r_isDiv     <= w_isDiv;
                  r_divByZero <= w_divByZero;
                  r_prodNeg   <= w_negA ^ w_negB;
                  r_quotNeg   <= w_negA ^ w_negB;
                  r_remNeg    <= w_negA;
                  r_count     <= '0;
                  r_operand   <= w_isDiv ? w_absB : w_absA;
                  r_acc       <= {{WIDTH{1'b0}}, (w_isDiv ? w_absA : w_absB)};
               end
            end
            RUN: begin
               if (!flush_i) begin
                  r_acc   <= r_isDiv ? w_divStep : w_mulStep;
                  r_count <= r_count + 1'b1;
               end
            end
            FIN: begin
               if (!flush_i && !r_divByZero) begin
                  r_hi <= w_resHi;
                  r_lo <= w_resLo;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO and done cycle,
// a monitor pops and compares on every done_o pulse.
module tb_muldiv_sequencer;

   localparam int WIDTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_i;
   logic [1:0]        op_i;
   logic [WIDTH-1:0]  src_a_i;
   logic [WIDTH-1:0]  src_b_i;
   logic              flush_i;
   logic              hi_we_i;
   logic              lo_we_i;
   logic [WIDTH-1:0]  wdata_i;
   logic              stall_o;
   logic              busy_o;
   logic              done_o;
   logic [WIDTH-1:0]  hi_o;
   logic [WIDTH-1:0]  lo_o;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          doneCycle;
   } expect_t;

   expect_t     scoreboard[$];
   expect_t     monItem;
   int          assertsEvaluated = 0;
   int          failures = 0;
   int          cycleCount = 0;
   logic [31:0] modelHi = '0;
   logic [31:0] modelLo = '0;

   muldiv_sequencer #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .src_a_i (src_a_i),
      .src_b_i (src_b_i),
      .flush_i (flush_i),
      .hi_we_i (hi_we_i),
      .lo_we_i (lo_we_i),
      .wdata_i (wdata_i),
      .stall_o (stall_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertsEvaluated++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: whole-word signed/unsigned arithmetic, truncating division.
   function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output bit dbz);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sq;
      logic signed [63:0] sr;
      logic [63:0]        p;
      sa  = $signed(a);
      sb  = $signed(b);
      dbz = 1'b0;
      hi  = modelHi;
      lo  = modelLo;
      case (op)
         2'd0: begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
         end
         2'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         2'd2: begin
            if (b == 32'd0) begin
               dbz = 1'b1;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               lo = sq[31:0];
               hi = sr[31:0];
            end
         end
         default: begin
            if (b == 32'd0) begin
               dbz = 1'b1;
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   // Issues one operation, optionally flushing it k cycles after accept, holding start_i
   // during the run, or attempting an MTLO mid-run; returns once the unit is idle again.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int flushAt, input bit holdStart, input bit mtloInRun);
      logic [31:0] eHi;
      logic [31:0] eLo;
      bit          dbz;
      int          stallCnt;
      int          lastBusy;
      int          startCycle;
      bit          finished;
      refModel(op, a, b, eHi, eLo, dbz);
      if (dbz) flushAt = 0;
      lastBusy = dbz ? 1 : 33;
      tick();
      start_i = 1'b1;
      op_i    = op;
      src_a_i = a;
      src_b_i = b;
      startCycle = cycleCount;
      if (flushAt == 0) scoreboard.push_back('{eHi, eLo, startCycle + lastBusy});
      #1;
      checkOutput("stallOnAccept", {63'd0, stall_o}, 64'd1);
      stallCnt = 1;
      finished = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         flush_i = 1'b0;
         lo_we_i = 1'b0;
         if (mtloInRun && k == 6) checkOutput("mtloIgnoredInRun", {32'd0, lo_o}, {32'd0, modelLo});
         if (!busy_o) begin
            finished = 1'b1;
            break;
         end
         if (stall_o) stallCnt++;
         start_i = holdStart && (k < lastBusy) && (k != flushAt);
         if (k == flushAt) flush_i = 1'b1;
         if (mtloInRun && k == 5) begin
            lo_we_i = 1'b1;
            wdata_i = 32'h0000ABCD;
         end
      end
      start_i = 1'b0;
      flush_i = 1'b0;
      lo_we_i = 1'b0;
      if (!finished) begin
         assertsEvaluated++;
         failures++;
         $display("[TB] FAIL opTimeout: busy_o still 1 after 40 cycles, expected 0 (op %0d)", op);
      end
      if (flushAt == 0 && !dbz) begin
         modelHi = eHi;
         modelLo = eLo;
      end
      if (flushAt == 0) checkOutput("stallCycles", 64'(stallCnt), 64'(lastBusy == 1 ? 1 : 33));
      checkOutput("hiAfterOp", {32'd0, hi_o}, {32'd0, modelHi});
      checkOutput("loAfterOp", {32'd0, lo_o}, {32'd0, modelLo});
   endtask

   task automatic applyMove(input bit toHi, input logic [31:0] data);
      tick();
      hi_we_i = toHi;
      lo_we_i = ~toHi;
      wdata_i = data;
      tick();
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      if (toHi) modelHi = data;
      else      modelLo = data;
      checkOutput(toHi ? "mthi" : "mtlo", {hi_o, lo_o}, {modelHi, modelLo});
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 7))
         0:       return 32'h00000000;
         1:       return 32'h00000001;
         2:       return 32'hFFFFFFFF;
         3:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done_o === 1'b1) begin
         if (scoreboard.size() == 0) begin
            assertsEvaluated++;
            failures++;
            $display("[TB] FAIL unexpectedDone: done_o=1 with empty scoreboard, expected 0 (cycle %0d)", cycleCount);
         end else begin
            monItem = scoreboard.pop_front();
            checkOutput("doneLatency", 64'(cycleCount), 64'(monItem.doneCycle));
            @(posedge clk);
            #1;
            checkOutput("resultHi", {32'd0, hi_o}, {32'd0, monItem.hi});
            checkOutput("resultLo", {32'd0, lo_o}, {32'd0, monItem.lo});
            checkOutput("busyAfterDone", {63'd0, busy_o}, 64'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          fAt;
      rst     = 1'b1;
      start_i = 1'b0;
      op_i    = 2'd0;
      src_a_i = '0;
      src_b_i = '0;
      flush_i = 1'b0;
      hi_we_i = 1'b0;
      lo_we_i = 1'b0;
      wdata_i = '0;
      repeat (3) tick();
      checkOutput("resetState", {hi_o, lo_o}, 64'd0);
      checkOutput("resetFlags", {61'd0, busy_o, stall_o, done_o}, 64'd0);
      rst = 1'b0;

      $display("[TB] directed operations");
      applyStimulus(2'd0, 32'hFFFFFFFD, 32'd5, 0, 1'b0, 1'b0);
      applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
      applyStimulus(2'd2, 32'hFFFFFFF9, 32'd2, 0, 1'b0, 1'b0);
      applyStimulus(2'd3, 32'd7, 32'd2, 0, 1'b0, 1'b0);
      applyMove(1'b1, 32'h11);
      applyMove(1'b0, 32'h22);
      applyStimulus(2'd3, 32'd7, 32'd0, 0, 1'b0, 1'b0);
      applyStimulus(2'd1, 32'd2, 32'd3, 10, 1'b0, 1'b0);
      applyStimulus(2'd1, 32'd2, 32'd3, 0, 1'b0, 1'b0);
      applyStimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
      applyMove(1'b0, 32'h0000ABCD);

      $display("[TB] start with flush in idle");
      tick();
      start_i = 1'b1;
      flush_i = 1'b1;
      op_i    = 2'd1;
      src_a_i = 32'd9;
      src_b_i = 32'd9;
      #1;
      checkOutput("stallWithFlush", {63'd0, stall_o}, 64'd0);
      tick();
      start_i = 1'b0;
      flush_i = 1'b0;
      checkOutput("notAcceptedOnFlush", {63'd0, busy_o}, 64'd0);

      $display("[TB] reset mid-operation");
      tick();
      start_i = 1'b1;
      op_i    = 2'd0;
      src_a_i = 32'd1234;
      src_b_i = 32'd5678;
      tick();
      start_i = 1'b0;
      repeat (5) tick();
      checkOutput("busyMidOp", {63'd0, busy_o}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      modelHi = '0;
      modelLo = '0;
      checkOutput("resetMidOpBusy", {63'd0, busy_o}, 64'd0);
      checkOutput("resetMidOpRegs", {hi_o, lo_o}, 64'd0);

      $display("[TB] randomized operations");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) applyMove($urandom_range(0, 1) == 1, $urandom);
         ra  = randOperand();
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : randOperand();
         fAt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 33)) : 0;
         applyStimulus(2'($urandom_range(0, 3)), ra, rb, fAt, $urandom_range(0, 1) == 1, 1'b0);
      end

      repeat (3) tick();
      checkOutput("scoreboardEmpty", 64'(scoreboard.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertsEvaluated, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit for the execute stage. Runs the MULT/MULTU/DIV/DIVU operations that the single-cycle ALU does not implement.
- Owns the architectural HI/LO registers and stalls the pipeline while an operation is in flight.
- Uses a radix-2 iterative engine: 32 iterations per operation, controlled by a small FSM.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  request a multiply/divide this cycle.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a_i  input  WIDTH  multiplicand, or dividend for DIV/DIVU.
- src_b_i  input  WIDTH  multiplier, or divisor for DIV/DIVU.
- flush_i  input  1  pipeline flush; aborts any operation.
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- stall_o  output  1  hold the upstream pipeline.
- busy_o  output  1  FSM not in IDLE.
- done_o  output  1  one-cycle completion pulse.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Interface fixed: single clock clk; rst is synchronous, active-high.
- Reset: state=IDLE, hi_o=0, lo_o=0, done_o=0, busy_o=0, stall_o=0, iteration counter=0. A reset asserted mid-operation discards the operation.
- States: IDLE, RUN, FIN.
- IDLE -> RUN when start_i=1, flush_i=0, and not a divide by zero.
  - On accept, latch op and operand magnitudes. Signed ops use absolute values.
  - Record result signs:
    - Product sign = a31^b31.
    - Quotient sign = a31^b31.
    - Remainder sign = a31.
  - Unsigned ops record all signs as positive.
  - Clear counter.
- IDLE -> FIN when start_i=1, flush_i=0, and src_b_i=0 with a DIV/DIVU op.
  - This is divide by zero: no iterations run and HI/LO are left unchanged.
- RUN performs one iteration per cycle for exactly WIDTH cycles, then goes to FIN.
  - Multiply: 2*WIDTH-bit shift-add accumulator.
  - Divide: restoring shift-subtract, with a WIDTH+1-bit partial remainder.
- FIN lasts one cycle with done_o=1.
  - On the edge leaving FIN, HI/LO are written with the sign-corrected result, except in the divide-by-zero case.
  - Multiply writes HI = upper word, LO = lower word of the 64-bit product.
  - Divide writes LO = quotient, HI = remainder.
  - FIN -> IDLE unconditionally.
- Latency: an accept at edge E0 gives done_o high during cycle E32..E33 and HI/LO updated at E33. Divide by zero gives done_o in the cycle after accept.
- stall_o = (IDLE & start_i & ~flush_i) | RUN. stall_o is 0 in FIN, so the issuing instruction advances and a following MFHI sees the new HI.
- busy_o = (state != IDLE).
- start_i is ignored outside IDLE; back-to-back operations need one IDLE cycle between them.
- flush_i in RUN or FIN:
  - Next state IDLE.
  - No HI/LO write.
  - done_o is forced to 0 in that cycle.
- flush_i together with start_i in IDLE: the request is not accepted.
- hi_we_i/lo_we_i are honoured only in IDLE and ignored otherwise.
  - They take effect even if start_i is accepted in the same cycle; the later result overwrites them.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. This is the natural wrap of the negate; no trap is raised.
- All arithmetic is modulo 2^WIDTH per word. Sign correction is two's-complement negation of the 64-bit product, or of the quotient and remainder separately.

Test Plan:
- Reset then MULT with a=0xFFFFFFFD (-3), b=5 -> stall_o high for 33 cycles including the accept cycle; done_o one pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy_o deasserts the cycle after done_o.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU with 7/2 -> LO=3, HI=1.
- DIVU with a=7, b=0 and prior HI/LO=0x11/0x22 -> done_o in the cycle after accept; HI/LO remain 0x11/0x22.
- MULTU with 2*3, flush_i asserted in the 10th RUN cycle -> IDLE next, done_o never pulses, HI/LO unchanged. A restarted MULTU 2*3 then gives LO=6, HI=0.
- DIV with 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Also apply lo_we_i=1, wdata_i=0xABCD during RUN -> ignored; the same write in IDLE sets LO=0xABCD next cycle.
